// File: rtl/inst_fetch_pkg.sv
// Shared widths, opcode constants, FSM encoding and queue entry layout for the
// instruction fetch block.
package inst_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [6:0] JAL_OPCODE = 7'b1101111;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [ADDR_WIDTH-1:0] EMPTY_ADDR = '0;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_pc;
  } iq_entry_t;

  // Sign-extended J-type immediate (byte offset, bit 0 always zero).
  function automatic logic [ADDR_WIDTH-1:0] j_imm(input logic [INST_WIDTH-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Show-ahead circular instruction queue with flush; head reads as zero when
// empty so decode never sees stale storage.
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  iq_entry_t push_data_i,
  input  logic      pop_i,
  output logic      valid_o,
  output iq_entry_t head_o,
  output logic      full_o,
  output logic      full_next_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;
  iq_entry_t     mem_q [DEPTH];

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign do_pop  = pop_i & valid_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + 1'b1;
      if (do_push) tail_d = tail_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  assign full_next_o = (count_d == FULL_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i && do_push) mem_q[tail_q] <= push_data_i;
  end

  assign head_o = valid_o ? mem_q[head_q] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, single-outstanding request FSM, static JAL
// prediction and the instruction queue feeding decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    IQ_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] clear_pc,
  output logic                  if_get_pc,
  output logic [ADDR_WIDTH-1:0] pc_get,
  input  logic                  if_get_inst,
  input  logic [INST_WIDTH-1:0] get_inst,
  output logic                  iq_valid,
  output logic [INST_WIDTH-1:0] iq_inst,
  output logic [ADDR_WIDTH-1:0] iq_pc,
  output logic                  iq_pred_taken,
  output logic [ADDR_WIDTH-1:0] iq_pred_pc,
  input  logic                  iq_pop
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  req_q;

  logic                  is_jal;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  resp_take;
  logic                  iq_full, iq_full_next;
  iq_entry_t             push_entry, head_entry;

  assign is_jal    = (get_inst[6:0] == JAL_OPCODE);
  assign next_pc   = is_jal ? (pc_q + j_imm(get_inst)) : (pc_q + 32'd4);
  assign resp_take = (state_q == ST_REQ) & if_get_inst & ~clear;

  // Dropped in the response cycle so the controller never re-fetches the old pc.
  assign if_get_pc = req_q & ~if_get_inst & ~clear;
  assign pc_get    = pc_q;

  assign push_entry = '{inst: get_inst, pc: pc_q, pred_taken: is_jal, pred_pc: next_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FLUSH;
      pc_q    <= RESET_PC;
      req_q   <= FALSE;
    end else if (rdy) begin
      if (clear) begin
        state_q <= ST_FLUSH;
        pc_q    <= clear_pc;
        req_q   <= FALSE;
      end else begin
        case (state_q)
          ST_FLUSH: begin
            state_q <= iq_full ? ST_HOLD : ST_REQ;
            req_q   <= ~iq_full;
          end
          ST_REQ: begin
            if (if_get_inst) begin
              pc_q    <= next_pc;
              state_q <= iq_full_next ? ST_HOLD : ST_REQ;
              req_q   <= ~iq_full_next;
            end
          end
          ST_HOLD: begin
            if (!iq_full) begin
              state_q <= ST_REQ;
              req_q   <= TRUE;
            end
          end
          default: begin
            state_q <= ST_FLUSH;
            req_q   <= FALSE;
          end
        endcase
      end
    end
  end

  inst_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (rdy),
    .flush_i     (clear),
    .push_i      (resp_take),
    .push_data_i (push_entry),
    .pop_i       (iq_pop),
    .valid_o     (iq_valid),
    .head_o      (head_entry),
    .full_o      (iq_full),
    .full_next_o (iq_full_next)
  );

  assign iq_inst       = head_entry.inst;
  assign iq_pc         = head_entry.pc;
  assign iq_pred_taken = head_entry.pred_taken;
  assign iq_pred_pc    = head_entry.pred_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: the bench plays the memory controller and
// keeps a reference PC and an expected-queue model built from the fetch rules.
module tb_inst_fetch;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] clear_pc = 32'h0;
  logic        if_get_pc;
  logic [31:0] pc_get;
  logic        if_get_inst = 1'b0;
  logic [31:0] get_inst = 32'h0;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic [31:0] iq_pred_pc;
  logic        iq_pop = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc = 32'h0;

  always #5 clk = ~clk;

  inst_fetch #(.IQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear), .clear_pc(clear_pc),
    .if_get_pc(if_get_pc), .pc_get(pc_get), .if_get_inst(if_get_inst), .get_inst(get_inst),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pred_taken(iq_pred_taken),
    .iq_pred_pc(iq_pred_pc), .iq_pop(iq_pop)
  );

  function automatic logic is_jal(input logic [31:0] inst);
    return inst[6:0] == 7'h6F;
  endfunction

  // Predicted next PC using signed integer offset arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
    logic [20:0] field;
    int          off;
    if (!is_jal(inst)) return pc + 32'd4;
    field = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    off = int'(field);
    if (inst[31]) off = off - (1 << 21);
    return pc + 32'(off);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(1, 0) == 1) r[6:0] = 7'h6F;
    else if (r[6:0] == 7'h6F) r[6:0] = 7'h13;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the request, check its address, answer after lat cycles.
  task automatic respond(input logic [31:0] inst, input int lat);
    int   w;
    exp_t e;
    w = 0;
    while (!if_get_pc && w < 20) begin
      cyc();
      w++;
    end
    n_checks++;
    if (if_get_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout: if_get_pc=%b required 1 after %0d cycles", if_get_pc, w);
    end
    n_checks++;
    if (pc_get !== m_pc) begin
      n_fail++;
      $display("FAIL req_pc: pc_get=%h required %h", pc_get, m_pc);
    end
    repeat (lat) cyc();
    n_checks++;
    if (pc_get !== m_pc || if_get_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL req_stable: pc_get=%h req=%b required %h/1", pc_get, if_get_pc, m_pc);
    end
    if_get_inst = 1'b1;
    get_inst = inst;
    @(negedge clk);
    n_checks++;
    if (if_get_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_gate: if_get_pc=%b required 0 in response cycle", if_get_pc);
    end
    cyc();
    if_get_inst = 1'b0;
    get_inst = $urandom;
    e.inst = inst;
    e.pc = m_pc;
    e.taken = is_jal(inst);
    e.pred = model_next(m_pc, inst);
    exp_q.push_back(e);
    m_pc = e.pred;
    $display("resp pc=%h inst=%h taken=%b next=%h depth=%0d", e.pc, inst, e.taken, e.pred, exp_q.size());
  endtask

  task automatic drain_one();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q[0];
    n_checks++;
    if (iq_valid !== 1'b1 || iq_inst !== e.inst || iq_pc !== e.pc ||
        iq_pred_taken !== e.taken || iq_pred_pc !== e.pred) begin
      n_fail++;
      $display("FAIL head: v=%b inst=%h pc=%h tk=%b pred=%h required 1 %h %h %b %h",
               iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_pc, e.inst, e.pc, e.taken, e.pred);
    end
    iq_pop = 1'b1;
    cyc();
    iq_pop = 1'b0;
    void'(exp_q.pop_front());
    $display("pop pc=%h inst=%h left=%0d", e.pc, e.inst, exp_q.size());
  endtask

  task automatic do_clear(input logic [31:0] target);
    clear = 1'b1;
    clear_pc = target;
    iq_pop = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_get_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_gate: if_get_pc=%b required 0", if_get_pc);
    end
    cyc();
    clear = 1'b0;
    iq_pop = 1'b0;
    exp_q.delete();
    m_pc = target;
    $display("clear target=%h", target);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (if_get_pc !== 1'b0 || iq_valid !== 1'b0 || pc_get !== 32'h0 || iq_inst !== 32'h0 ||
        iq_pc !== 32'h0 || iq_pred_taken !== 1'b0 || iq_pred_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: req=%b v=%b pc_get=%h inst=%h required all 0", if_get_pc, iq_valid, pc_get, iq_inst);
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    n_checks++;
    if (if_get_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: if_get_pc=%b required 0", if_get_pc);
    end
    cyc();
    n_checks++;
    if (if_get_pc !== 1'b1 || pc_get !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: req=%b pc_get=%h required 1/00000000", if_get_pc, pc_get);
    end
    $display("reset released");
  endtask

  task automatic test_sequential();
    logic [31:0] want [3];
    want[0] = 32'h0;
    want[1] = 32'h4;
    want[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_pc !== want[i]) begin
        n_fail++;
        $display("FAIL seq_pc: model pc=%h required %h", m_pc, want[i]);
      end
      respond(32'h00000013, 5);
    end
    while (exp_q.size() > 0) drain_one();
  endtask

  task automatic test_jal();
    respond(32'h00000013, 1);
    respond(32'h0080006F, 2);
    n_checks++;
    if (exp_q[1].pred !== 32'h18 || iq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_fwd: pred=%h required 00000018", exp_q[1].pred);
    end
    n_checks++;
    if (pc_get !== 32'h18) begin
      n_fail++;
      $display("FAIL jal_next: pc_get=%h required 00000018", pc_get);
    end
    while (exp_q.size() > 0) drain_one();
    do_clear(32'h100);
    respond(32'hFF9FF06F, 3);
    n_checks++;
    if (iq_pred_pc !== 32'hF8 || iq_pred_taken !== 1'b1 || pc_get !== 32'hF8) begin
      n_fail++;
      $display("FAIL jal_back: pred=%h tk=%b pc_get=%h required 000000f8 1 000000f8", iq_pred_pc, iq_pred_taken, pc_get);
    end
    while (exp_q.size() > 0) drain_one();
  endtask

  task automatic test_full();
    int w;
    for (int i = 0; i < DEPTH; i++) respond(rand_inst(), $urandom_range(3, 0));
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if_get_pc !== 1'b0 || iq_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold: req=%b v=%b required 0/1", if_get_pc, iq_valid);
      end
      cyc();
    end
    drain_one();
    w = 0;
    while (!if_get_pc && w < 4) begin
      cyc();
      w++;
    end
    n_checks++;
    if (if_get_pc !== 1'b1 || pc_get !== m_pc) begin
      n_fail++;
      $display("FAIL full_resume: req=%b pc_get=%h required 1/%h", if_get_pc, pc_get, m_pc);
    end
    while (exp_q.size() > 0) drain_one();
  endtask

  task automatic test_clear();
    respond(32'h00000013, 1);
    respond(rand_inst(), 2);
    cyc();
    do_clear(32'h200);
    if_get_inst = 1'b1;
    get_inst = 32'h0080006F;
    @(negedge clk);
    n_checks++;
    if (if_get_pc !== 1'b0 || iq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: req=%b v=%b required 0/0", if_get_pc, iq_valid);
    end
    cyc();
    if_get_inst = 1'b0;
    n_checks++;
    if (iq_valid !== 1'b0 || pc_get !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_drop: v=%b pc_get=%h required 0/00000200", iq_valid, pc_get);
    end
    respond(32'h00000013, 1);
    while (exp_q.size() > 0) drain_one();
  endtask

  task automatic test_rdy();
    int w;
    w = 0;
    while (!if_get_pc && w < 10) begin
      cyc();
      w++;
    end
    rdy = 1'b0;
    if_get_inst = 1'b1;
    get_inst = 32'h0080006F;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (pc_get !== m_pc || iq_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rdy_hold: pc_get=%h v=%b required %h/0", pc_get, iq_valid, m_pc);
      end
    end
    rdy = 1'b1;
    if_get_inst = 1'b0;
    #1;
    n_checks++;
    if (if_get_pc !== 1'b1 || pc_get !== m_pc) begin
      n_fail++;
      $display("FAIL rdy_resume: req=%b pc_get=%h required 1/%h", if_get_pc, pc_get, m_pc);
    end
    respond(32'h00000013, 2);
    respond(rand_inst(), 0);
    while (exp_q.size() > 0) drain_one();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      respond(rand_inst(), $urandom_range(4, 0));
      if (exp_q.size() >= 12 || $urandom_range(1, 0) == 1) drain_one();
    end
    while (exp_q.size() > 0) drain_one();
    n_checks++;
    if (iq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_empty: iq_valid=%b required 0", iq_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_full();
    test_clear();
    test_rdy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
